// File: rtl/signal_phase_controller.sv
// Traffic phase sequencer: all-red -> green -> yellow per road, green sized from
// the served road's averaged count, with emergency preemption and hold.
module signal_phase_controller #(
  parameter int unsigned MIN_GREEN   = 5,
  parameter int unsigned MAX_GREEN   = 30,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned YELLOW_T    = 3,
  parameter int unsigned ALLRED_T    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [7:0]  avg_n,
  input  logic [7:0]  avg_s,
  input  logic [7:0]  avg_e,
  input  logic [7:0]  avg_w,
  input  logic        emg_req,
  input  logic [1:0]  emg_road,
  output logic [1:0]  next_road,
  output logic [11:0] lights,
  output logic [7:0]  green_len,
  output logic [1:0]  state
);

  localparam int unsigned ROAD_W  = 2;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned LIGHT_W = 12;
  localparam int unsigned SIZE_W  = CNT_W + 1;

  localparam logic [CNT_W-1:0]   ALLRED_LAST = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0]   YELLOW_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0]   MIN_LAST    = CNT_W'(MIN_GREEN - 1);
  localparam logic [LIGHT_W-1:0] ALL_RED_LIGHTS = 12'b100_100_100_100;

  typedef enum logic [1:0] {
    ST_ALL_RED = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ROAD_W-1:0]   cur_road_q, cur_road_d;
  logic [ROAD_W-1:0]   next_road_q, next_road_d;
  logic [CNT_W-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0]    green_len_q, green_len_d;
  logic [LIGHT_W-1:0]  lights_q, lights_d;

  logic [ROAD_W-1:0]   serve_road;
  logic [CNT_W-1:0]    serve_avg;
  logic [SIZE_W-1:0]   g_raw;
  logic [CNT_W-1:0]    g_sized;
  logic [CNT_W-1:0]    green_last;
  logic                preempt;
  logic                hold;
  logic [2:0]          lamp;

  // A request pending at the all-red exit edge decides the road being served
  always_comb begin
    serve_road = emg_req ? emg_road : next_road_q;
    unique case (serve_road)
      2'd0:    serve_avg = avg_n;
      2'd1:    serve_avg = avg_s;
      2'd2:    serve_avg = avg_e;
      default: serve_avg = avg_w;
    endcase
    g_raw   = SIZE_W'(MIN_GREEN) + SIZE_W'(serve_avg >> SCALE_SHIFT);
    g_sized = (g_raw > SIZE_W'(MAX_GREEN)) ? CNT_W'(MAX_GREEN) : g_raw[CNT_W-1:0];
  end

  assign green_last = green_len_q - CNT_W'(1);
  assign preempt    = emg_req && (emg_road != cur_road_q);
  assign hold       = emg_req && (emg_road == cur_road_q);

  // Next-state and phase bookkeeping
  always_comb begin
    state_d     = state_q;
    cur_road_d  = cur_road_q;
    next_road_d = next_road_q;
    timer_d     = timer_q;
    green_len_d = green_len_q;

    unique case (state_q)
      ST_ALL_RED: begin
        next_road_d = serve_road;
        if (tick) begin
          if (timer_q == ALLRED_LAST) begin
            state_d     = ST_GREEN;
            cur_road_d  = serve_road;
            green_len_d = g_sized;
            timer_d     = '0;
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
      end

      ST_GREEN: begin
        if (tick) begin
          if (preempt && (timer_q >= MIN_LAST)) begin
            state_d     = ST_YELLOW;
            next_road_d = emg_road;
            timer_d     = '0;
          end else if (timer_q >= green_last) begin
            // Emergency on the served road saturates the timer here
            if (!hold) begin
              state_d     = ST_YELLOW;
              next_road_d = cur_road_q + ROAD_W'(1);
              timer_d     = '0;
            end
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
      end

      ST_YELLOW: begin
        if (emg_req) begin
          next_road_d = emg_road;
        end
        if (tick) begin
          if (timer_q == YELLOW_LAST) begin
            state_d = ST_ALL_RED;
            timer_d = '0;
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_ALL_RED;
        timer_d = '0;
      end
    endcase
  end

  // Lamp decode from the upcoming state so lights stay registered
  always_comb begin
    lights_d = ALL_RED_LIGHTS;
    lamp     = 3'b100;
    if (state_d == ST_GREEN) begin
      lamp = 3'b001;
    end else if (state_d == ST_YELLOW) begin
      lamp = 3'b010;
    end
    unique case (cur_road_d)
      2'd0:    lights_d[2:0]  = lamp;
      2'd1:    lights_d[5:3]  = lamp;
      2'd2:    lights_d[8:6]  = lamp;
      default: lights_d[11:9] = lamp;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_ALL_RED;
      cur_road_q  <= '0;
      next_road_q <= '0;
      timer_q     <= '0;
      green_len_q <= '0;
      lights_q    <= ALL_RED_LIGHTS;
    end else begin
      state_q     <= state_d;
      cur_road_q  <= cur_road_d;
      next_road_q <= next_road_d;
      timer_q     <= timer_d;
      green_len_q <= green_len_d;
      lights_q    <= lights_d;
    end
  end

  assign next_road = next_road_q;
  assign lights    = lights_q;
  assign green_len = green_len_q;
  assign state     = state_q;

endmodule

// File: tb/tb_signal_phase_controller.sv
// Directed bench for signal_phase_controller: rotation, sizing/clamp, preemption,
// emergency hold, mid-yellow reset and tick gating, with a next_road scoreboard.
module tb_signal_phase_controller;

  localparam int unsigned MIN_GREEN   = 5;
  localparam int unsigned MAX_GREEN   = 30;
  localparam int unsigned SCALE_SHIFT = 2;
  localparam int unsigned YELLOW_T    = 3;
  localparam int unsigned ALLRED_T    = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tick = 1'b0;
  logic [7:0]  avg_n = 8'd20;
  logic [7:0]  avg_s = 8'd0;
  logic [7:0]  avg_e = 8'd255;
  logic [7:0]  avg_w = 8'd8;
  logic        emg_req = 1'b0;
  logic [1:0]  emg_road = 2'd0;
  logic [1:0]  next_road;
  logic [11:0] lights;
  logic [7:0]  green_len;
  logic [1:0]  state;

  int checks = 0;
  int failures = 0;
  logic [1:0] exp_q[$];
  logic [1:0] prev_state = 2'd0;

  signal_phase_controller #(
    .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN), .SCALE_SHIFT(SCALE_SHIFT),
    .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .avg_n(avg_n), .avg_s(avg_s), .avg_e(avg_e), .avg_w(avg_w),
    .emg_req(emg_req), .emg_road(emg_road),
    .next_road(next_road), .lights(lights), .green_len(green_len), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int glen_model(input int avg);
    int g;
    g = int'(MIN_GREEN) + (avg >> SCALE_SHIFT);
    return (g > int'(MAX_GREEN)) ? int'(MAX_GREEN) : g;
  endfunction

  function automatic logic [11:0] lamp_model(input int st, input int road);
    logic [11:0] l;
    l = 12'h924;
    if (st == 1) l[3*road +: 3] = 3'b001;
    else if (st == 2) l[3*road +: 3] = 3'b010;
    return l;
  endfunction

  task automatic tick_n(input int n);
    repeat (n) begin
      @(negedge clk) tick = 1'b1;
      @(negedge clk) tick = 1'b0;
    end
  endtask

  // Scoreboard pop on every green->yellow edge, plus the single-active-road invariant
  always @(negedge clk) begin
    int nonred;
    nonred = 0;
    for (int r = 0; r < 4; r++) if (lights[3*r+2] == 1'b0) nonred++;
    chk("one_active_road", 32'(nonred <= 1), 32'd1);
    if (reset && state == 2'd2 && prev_state == 2'd1) begin
      chk("yellow_sched_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("yellow_next_road", 32'(next_road), 32'(exp_q.pop_front()));
    end
    prev_state = state;
  end

  // One full phase cycle starting from all-red with the timer cleared
  task automatic serve(input int road, input int avg);
    int glen;
    glen = glen_model(avg);
    for (int i = 1; i <= int'(ALLRED_T); i++) begin
      tick_n(1);
      if (i < int'(ALLRED_T)) chk("allred_hold", 32'(state), 32'd0);
    end
    chk("green_state", 32'(state), 32'd1);
    chk("green_lights", 32'(lights), 32'(lamp_model(1, road)));
    chk("green_len", 32'(green_len), 32'(glen));
    chk("next_road_stable", 32'(next_road), 32'(road));
    exp_q.push_back(2'((road + 1) % 4));
    for (int i = 1; i <= glen; i++) begin
      tick_n(1);
      if (i < glen) chk("green_hold", 32'(state), 32'd1);
    end
    chk("yellow_state", 32'(state), 32'd2);
    chk("yellow_lights", 32'(lights), 32'(lamp_model(2, road)));
    for (int i = 1; i <= int'(YELLOW_T); i++) begin
      tick_n(1);
      if (i < int'(YELLOW_T)) chk("yellow_hold", 32'(state), 32'd2);
    end
    chk("allred_state", 32'(state), 32'd0);
    chk("allred_lights", 32'(lights), 32'h924);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_lights", 32'(lights), 32'h924);
    chk("reset_next_road", 32'(next_road), 32'd0);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_green_len", 32'(green_len), 32'd0);
    reset = 1'b1;

    // Rotation N,S,E,W twice; covers first phase, minimum and clamped sizing
    for (int k = 0; k < 8; k++) begin
      case (k % 4)
        0: serve(0, int'(avg_n));
        1: serve(1, int'(avg_s));
        2: serve(2, int'(avg_e));
        default: serve(3, int'(avg_w));
      endcase
    end

    // Preemption: W requested while N is green at timer=1
    tick_n(ALLRED_T);
    chk("pre_green_road", 32'(lights), 32'(lamp_model(1, 0)));
    exp_q.push_back(2'd3);
    tick_n(1);
    emg_req = 1'b1;
    emg_road = 2'd3;
    for (int i = 0; i < 3; i++) begin
      tick_n(1);
      chk("pre_green_min", 32'(state), 32'd1);
    end
    tick_n(1);
    chk("pre_yellow_state", 32'(state), 32'd2);
    chk("pre_yellow_next", 32'(next_road), 32'd3);
    emg_req = 1'b0;
    tick_n(YELLOW_T);
    chk("pre_allred", 32'(state), 32'd0);
    serve(3, int'(avg_w));

    // Hold: emergency on the served road keeps N green past its length
    tick_n(ALLRED_T);
    chk("hold_green_len", 32'(green_len), 32'd10);
    emg_req = 1'b1;
    emg_road = 2'd0;
    for (int i = 0; i < 20; i++) begin
      tick_n(1);
      chk("hold_green", 32'(state), 32'd1);
    end
    emg_req = 1'b0;
    exp_q.push_back(2'd1);
    tick_n(1);
    chk("hold_release_yellow", 32'(state), 32'd2);
    chk("hold_release_lights", 32'(lights), 32'(lamp_model(2, 0)));
    tick_n(YELLOW_T);

    // Reset during S yellow with tick low
    tick_n(ALLRED_T);
    chk("s_green_len", 32'(green_len), 32'd5);
    exp_q.push_back(2'd2);
    tick_n(5);
    chk("s_yellow", 32'(state), 32'd2);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    chk("mid_reset_lights", 32'(lights), 32'h924);
    chk("mid_reset_state", 32'(state), 32'd0);
    chk("mid_reset_timer", 32'(dut.timer_q), 32'd0);
    chk("mid_reset_next", 32'(next_road), 32'd0);
    chk("mid_reset_glen", 32'(green_len), 32'd0);
    reset = 1'b1;
    repeat (50) begin
      @(negedge clk);
      chk("idle_no_tick", 32'(state), 32'd0);
    end
    chk("idle_lights", 32'(lights), 32'h924);
    chk("idle_timer", 32'(dut.timer_q), 32'd0);
    tick_n(ALLRED_T);
    chk("post_reset_green", 32'(lights), 32'(lamp_model(1, 0)));
    chk("post_reset_glen", 32'(green_len), 32'd10);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/signal_phase_controller.md
Name: signal_phase_controller

Overview:
- Downstream consumer of the four per-road sensor averaging blocks (N, S, E, W).
- Runs the green/yellow/all-red phase cycle.
- Sizes each green phase from the served road's averaged vehicle count.
- Drives next_road back to the sensors so each sensor shifts in a new sample once per served phase.

Parameters:
MIN_GREEN, 5, minimum green length in ticks (1..255)
MAX_GREEN, 30, maximum green length in ticks (MIN_GREEN..255)
SCALE_SHIFT, 2, right-shift applied to avg when sizing green
YELLOW_T, 3, yellow length in ticks (>=1)
ALLRED_T, 2, all-red clearance length in ticks (>=1)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  reset, synchronous, active-low
tick  input  1  one-cycle timebase strobe; all phase timers advance only on clk edges with tick=1
avg_n  input  8  averaged vehicle count, north (road 0)
avg_s  input  8  averaged vehicle count, south (road 1)
avg_e  input  8  averaged vehicle count, east (road 2)
avg_w  input  8  averaged vehicle count, west (road 3)
emg_req  input  1  emergency preemption request, level
emg_road  input  2  road to preempt to while emg_req=1
next_road  output  2  road to receive the next green; fed to sensors
lights  output  12  {W,E,S,N}, each {R,Y,G}, one-hot per road
green_len  output  8  green length latched for current/last green phase
state  output  2  0=ALL_RED, 1=GREEN, 2=YELLOW (3 unused)

Behaviour:
- Reset (reset=0 at clk edge, regardless of tick or state):
  - state=ALL_RED, cur_road=0, next_road=0, timer=0, green_len=0.
  - lights=12'b100_100_100_100.
  - Mid-phase reset takes effect on the next edge; no yellow is inserted.
- Road successor: succ(r)=(r+1) mod 4, giving order N→S→E→W→N.
- Timer: 8-bit. Increments only on tick. Cleared on every state change.
- ALL_RED:
  - All roads red.
  - On tick with timer==ALLRED_T-1: go to GREEN, cur_road<=next_road.
  - On the same edge, latch green_len from the avg of next_road.
- green_len sizing:
  - g = MIN_GREEN + (avg >> SCALE_SHIFT), computed at 9 bits.
  - Clamp: if g>MAX_GREEN, use MAX_GREEN.
  - Result is always >= MIN_GREEN.
- GREEN:
  - cur_road shows G; all other roads R.
  - Normal exit: on tick with timer==green_len-1 → YELLOW, and next_road<=succ(cur_road).
  - Preemption exit: if emg_req=1 and emg_road!=cur_road, exit early on tick once timer>=MIN_GREEN-1 → YELLOW, and next_road<=emg_road.
  - Emergency on the current road: if emg_req=1 and emg_road==cur_road, the timer saturates at green_len-1 and the green holds.
    - After emg_req drops, the first tick with timer==green_len-1 exits normally.
- YELLOW:
  - cur_road shows Y; all other roads R.
  - If emg_req=1 on any edge, next_road<=emg_road.
  - On tick with timer==YELLOW_T-1 → ALL_RED.
- ALL_RED preemption: emg_req=1 on any edge also sets next_road<=emg_road.
- Decision time: next_road is re-evaluated only at the GREEN→ALL_RED-bound edges above. It is held stable through GREEN.
  - Consequence: each sensor sees exactly one next_road transition per cycle of phases.
- Return from preemption: the successor of the preempting road is served next.
  - Example: W preempts N; order continues W→N.
- tick=0: state, timer and outputs hold. Only emg_req may update next_road in YELLOW or ALL_RED.
- Outputs are registered; lights is decoded from registered state and cur_road.
- Invariant: never more than one road shows non-red.

Test Plan:
- Reset/first phase: reset=0 for 2 clks, then 1. lights=12'h924 and next_road=0 immediately after reset.
  - After 2 ticks, N is green with avg_n=20 → green_len=10.
  - N stays green for exactly 10 ticks, then yellow for 3 ticks.
- Sizing/clamp: avg_s=0 → green_len=5. avg_e=255 → g=68, clamped to 30.
  - S green lasts 5 ticks; E green lasts 30 ticks.
- Rotation: run 8 phases with no emergency.
  - next_road sequence at yellow entries is 1,2,3,0,1,2,3,0.
  - Green order is N,S,E,W,N,...
- Preemption: during N green at timer=1, assert emg_req with emg_road=3.
  - N yellow on the tick where timer=4 (5 green ticks total); next_road=3.
  - Then all-red, then W green; next served after W is N.
- Hold: emg_req=1 with emg_road=cur_road=N, green_len=10, held for 20 ticks.
  - N stays green for 20 ticks.
  - N goes yellow on the first tick after release.
- Reset mid-yellow, plus tick gating:
  - Assert reset during S yellow with tick=0. Next edge: lights=12'h924, state=0, timer=0.
  - Then hold tick=0 for 50 clks: no state change.
